// File: rtl/conv_code_pkg.sv
// Shared types and code constants for the K=5 rate-1/2 convolutional encoder path.
package conv_code_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DATA = 2'd2,
    TAIL = 2'd3
  } state_e;

  localparam int K            = 5;
  localparam int TAIL_LEN_DEF = K - 1;

  // Generator taps over the window {newest input, s[3:0]}
  localparam logic [K-1:0] G1 = 5'b11010;
  localparam logic [K-1:0] G2 = 5'b10111;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_noise_gate.sv
// Balanced-noise gate: allows at most one symbol flip in any NOISE_WIN consecutive valid symbols.
module conv_noise_gate #(
  parameter int NOISE_WIN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic noise_req,
  input  logic enc_valid,
  output logic noise_en
);

  localparam int GAP_W = $clog2(NOISE_WIN + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(NOISE_WIN);

  logic [GAP_W-1:0] gap_q, gap_d;

  // gap_q counts valid symbols since the last flip, saturating once a flip is allowed again
  always_comb begin
    noise_en = noise_req & enc_valid & (gap_q >= GAP_MAX);
    gap_d    = gap_q;
    if (noise_en) begin
      gap_d = GAP_W'(1);
    end else if (enc_valid && (gap_q < GAP_MAX)) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gap_q <= GAP_MAX;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/conv_frame_sched.sv
// Two-requester round-robin frame scheduler: serialises a frame LSB-first, appends a zero tail
// to flush the encoder, and gates the channel-noise injector.
module conv_frame_sched
  import conv_code_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int TAIL_LEN  = TAIL_LEN_DEF,
  parameter int NOISE_WIN = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  input  logic [2*FRAME_LEN-1:0] req_data,
  output logic [1:0]             req_ready,
  output logic                   enc_in,
  output logic                   enc_valid,
  output logic                   enc_last,
  output logic                   enc_owner,
  input  logic                   noise_req,
  output logic                   noise_en,
  output logic                   busy,
  output state_e                 dbg_state
);

  localparam int CNT_W = $clog2(max2(FRAME_LEN, TAIL_LEN));

  state_e               state_q;
  logic                 rr_ptr_q;
  logic                 owner_q;
  logic [FRAME_LEN-1:0] sreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 enc_in_q;
  logic                 enc_valid_q;
  logic                 enc_last_q;

  logic                 grant_idx;
  logic [FRAME_LEN-1:0] grant_data;

  // Handshake: a frame is captured on the rising edge where req_valid[i] & req_ready[i];
  // req_ready is a one-cycle grant raised only in IDLE, and requests are never latched.
  always_comb begin
    grant_idx  = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    grant_data = grant_idx ? req_data[FRAME_LEN +: FRAME_LEN] : req_data[0 +: FRAME_LEN];
    req_ready  = '0;
    if (!reset && (state_q == IDLE) && (|req_valid)) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      enc_in_q    <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            owner_q <= grant_idx;
            sreg_q  <= grant_data;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          rr_ptr_q    <= ~owner_q;
          cnt_q       <= '0;
          enc_in_q    <= sreg_q[0];
          sreg_q      <= sreg_q >> 1;
          enc_valid_q <= 1'b1;
          state_q     <= DATA;
        end
        DATA: begin
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            cnt_q      <= '0;
            enc_in_q   <= 1'b0;
            enc_last_q <= (TAIL_LEN == 1);
            state_q    <= TAIL;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            enc_in_q <= sreg_q[0];
            sreg_q   <= sreg_q >> 1;
          end
        end
        TAIL: begin
          if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
            cnt_q       <= '0;
            enc_valid_q <= 1'b0;
            enc_last_q  <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            enc_last_q <= (cnt_q == CNT_W'(TAIL_LEN - 2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enc_in    = enc_in_q;
  assign enc_valid = enc_valid_q;
  assign enc_last  = enc_last_q;
  assign enc_owner = owner_q;
  assign busy      = (state_q == DATA) || (state_q == TAIL);
  assign dbg_state = state_q;

  conv_noise_gate #(
    .NOISE_WIN(NOISE_WIN)
  ) u_noise_gate (
    .clock    (clock),
    .reset    (reset),
    .noise_req(noise_req),
    .enc_valid(enc_valid_q),
    .noise_en (noise_en)
  );

endmodule

// File: tb/tb_conv_frame_sched.sv
// Bench for conv_frame_sched: vector table plus multi-cycle corner sequences, scoreboarded symbol stream.
module tb_conv_frame_sched;
  import conv_code_pkg::*;

  localparam int FL   = 16;
  localparam int TL   = 4;
  localparam int NW   = 4;
  localparam int SYMS = FL + TL;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [2*FL-1:0] req_data = '0;
  logic [1:0]      req_ready;
  logic            enc_in, enc_valid, enc_last, enc_owner;
  logic            noise_req = 1'b0;
  logic            noise_en, busy;
  state_e          dbg_state;

  conv_frame_sched #(.FRAME_LEN(FL), .TAIL_LEN(TL), .NOISE_WIN(NW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_in(enc_in), .enc_valid(enc_valid), .enc_last(enc_last),
    .enc_owner(enc_owner), .noise_req(noise_req), .noise_en(noise_en), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: {enc_in, enc_last, enc_owner} per valid symbol
  logic [2:0] exp_q[$];

  task automatic push_frame(input logic [FL-1:0] data, input logic owner);
    for (int i = 0; i < FL; i++) exp_q.push_back({data[i], 1'b0, owner});
    for (int i = 0; i < TL; i++) exp_q.push_back({1'b0, (i == TL - 1), owner});
  endtask

  // monitor: scoreboard pop, noise-rule model, reference encoder
  logic [3:0]      enc_st_m = '0;
  int              gap_m = NW;
  int              pos = 0;
  int              idle_run = 0;
  int              gap_seen = -1;
  logic [SYMS-1:0] r1_buf = '0;
  logic [SYMS-1:0] r2_buf = '0;

  always @(negedge clock) begin
    logic       exp_ne;
    logic [2:0] e;
    logic [4:0] w;
    if (reset) begin
      exp_q.delete();
      gap_m = NW; enc_st_m = '0; pos = 0; idle_run = 0;
    end else begin
      exp_ne = noise_req & enc_valid & (gap_m >= NW);
      check("noise_en", 32'(noise_en), 32'(exp_ne));
      if (enc_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_extra: actual=symbol expected=none");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sym%0d", pos), 32'({enc_in, enc_last, enc_owner}), 32'(e));
        end
        w = {enc_in, enc_st_m};
        if (pos < SYMS) begin
          r1_buf[pos] = ^(w & G1);
          r2_buf[pos] = ^(w & G2);
        end
        enc_st_m = {enc_in, enc_st_m[3:1]};
        if (idle_run != 0) gap_seen = idle_run;
        idle_run = 0;
        if (enc_last) begin
          check("last_pos", pos, SYMS - 1);
          check("enc_state_flushed", 32'(enc_st_m), 32'(0));
          pos = 0;
        end else begin
          pos++;
        end
      end else begin
        idle_run++;
      end
      if (exp_ne) gap_m = 1;
      else if (enc_valid && gap_m < NW) gap_m++;
    end
  end

  // hard-decision Viterbi, terminated in state 0
  function automatic logic [FL-1:0] viterbi(input logic [SYMS-1:0] r1, input logic [SYMS-1:0] r2);
    int              pm[16];
    int              pmn[16];
    logic [SYMS-1:0] path[16];
    logic [SYMS-1:0] pathn[16];
    logic [3:0]      sv, ns;
    logic [4:0]      w;
    logic            bb;
    int              m;
    for (int s = 0; s < 16; s++) begin pm[s] = (s == 0) ? 0 : 1000; path[s] = '0; end
    for (int t = 0; t < SYMS; t++) begin
      for (int s = 0; s < 16; s++) begin pmn[s] = 1 << 20; pathn[s] = '0; end
      for (int s = 0; s < 16; s++) begin
        for (int b = 0; b < 2; b++) begin
          sv = 4'(s);
          bb = (b == 1);
          w  = {bb, sv};
          ns = {bb, sv[3:1]};
          m  = pm[s] + int'(^(w & G1) ^ r1[t]) + int'(^(w & G2) ^ r2[t]);
          if (m < pmn[ns]) begin
            pmn[ns]      = m;
            pathn[ns]    = path[s];
            pathn[ns][t] = bb;
          end
        end
      end
      pm   = pmn;
      path = pathn;
    end
    return path[0][FL-1:0];
  endfunction

  // driver tasks
  task automatic wait_accept(input int budget, output logic [1:0] rdy, output int waited);
    rdy = '0;
    waited = 0;
    while (waited < budget) begin
      @(negedge clock);
      waited++;
      if (req_ready != 2'b00) begin
        rdy = req_ready;
        break;
      end
    end
  endtask

  task automatic wait_last(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (enc_last) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  rv;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  exp_rdy;
    bit          hold;
  } vec_t;

  task automatic run_frame(input vec_t v, input bit already_driven);
    logic [1:0]    rdy;
    int            waited;
    bit            ok;
    logic [FL-1:0] dat;
    if (!already_driven) begin
      @(posedge clock); #1;
      req_valid = v.rv;
      req_data  = {v.d1, v.d0};
    end
    wait_accept(8, rdy, waited);
    check("grant", 32'(rdy), 32'(v.exp_rdy));
    if (already_driven) check("b2b_accept_wait", waited, 1);
    if (rdy == 2'b00) return;
    dat = rdy[1] ? v.d1 : v.d0;
    push_frame(dat, rdy[1]);
    @(posedge clock); #1;
    if (!v.hold) req_valid = '0;
    @(negedge clock);
    check("load_ready", 32'(req_ready), 32'(0));
    check("load_valid", 32'(enc_valid), 32'(0));
    wait_last(40, ok);
    check("last_seen", 32'(ok), 32'(1));
    check("sb_drained", exp_q.size(), 0);
    check("viterbi", 32'(viterbi(r1_buf, r2_buf)), 32'(dat));
    if (already_driven) check("bubble", gap_seen, 2);
  endtask

  task automatic noise_frame(input logic [FL-1:0] data, input logic [SYMS-1:0] req_mask,
                             input logic [SYMS-1:0] exp_mask);
    logic [1:0]      rdy;
    int              waited;
    logic [SYMS-1:0] got;
    logic            last_at_end;
    @(posedge clock); #1;
    req_valid = 2'b01;
    req_data  = {16'h0000, data};
    wait_accept(8, rdy, waited);
    check("noise_grant", 32'(rdy), 32'(2'b01));
    push_frame(data, 1'b0);
    @(posedge clock); #1 req_valid = '0;
    got = '0;
    last_at_end = 1'b0;
    for (int k = 1; k <= SYMS; k++) begin
      @(posedge clock); #1 noise_req = req_mask[k-1];
      @(negedge clock);
      got[k-1] = noise_en;
      if (k == SYMS) last_at_end = enc_last;
    end
    @(posedge clock); #1 noise_req = 1'b0;
    check("noise_mask", 32'(got), 32'(exp_mask));
    check("noise_last", 32'(last_at_end), 32'(1));
    check("noise_sb_drained", exp_q.size(), 0);
  endtask

  vec_t tbl[6];

  initial begin
    logic [1:0] rdy;
    int         waited;
    bit         prev_hold;
    logic       rr_m;
    vec_t       v;

    tbl[0] = '{1'b0, 2'b01, 16'hA5C3, 16'h0000, 2'b01, 1'b0};
    tbl[1] = '{1'b0, 2'b10, 16'h0000, 16'h3C5A, 2'b10, 1'b0};
    tbl[2] = '{1'b0, 2'b01, 16'hF00D, 16'h0000, 2'b01, 1'b0};
    tbl[3] = '{1'b1, 2'b11, 16'h1234, 16'hBEEF, 2'b01, 1'b1};
    tbl[4] = '{1'b0, 2'b11, 16'h1234, 16'hBEEF, 2'b10, 1'b1};
    tbl[5] = '{1'b0, 2'b11, 16'h1234, 16'hBEEF, 2'b01, 1'b0};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_outputs", 32'({req_ready, enc_in, enc_valid, enc_last, enc_owner, noise_en, busy}), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    prev_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) pulse_reset();
      run_frame(tbl[i], prev_hold);
      prev_hold = tbl[i].hold;
    end

    // constant noise request: flips on symbols 1,5,9,13,17
    noise_frame(16'h5A5A, {SYMS{1'b1}}, 20'h11111);
    // requests on symbols 3,5,7: 3 and 7 flip, 5 blocked
    noise_frame(16'h0F0F, 20'h00054, 20'h00044);

    // reset on the 8th DATA cycle aborts the frame without a tail
    @(posedge clock); #1;
    req_valid = 2'b01;
    req_data  = {16'h0000, 16'hC0DE};
    wait_accept(8, rdy, waited);
    check("abort_grant", 32'(rdy), 32'(2'b01));
    push_frame(16'hC0DE, 1'b0);
    @(posedge clock); #1 req_valid = '0;
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("abort_valid", 32'(enc_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_sb_flushed", exp_q.size(), 0);
    v = '{1'b0, 2'b11, 16'h7E81, 16'h8001, 2'b01, 1'b0};
    run_frame(v, 1'b0);

    // random frames with an independent round-robin model
    rr_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v.rst = 1'b0;
      v.rv  = 2'($urandom_range(1, 3));
      v.d0  = 16'($urandom_range(0, 65535));
      v.d1  = 16'($urandom_range(0, 65535));
      if (v.rv == 2'b11) v.exp_rdy = rr_m ? 2'b10 : 2'b01;
      else v.exp_rdy = v.rv;
      v.hold = 1'b0;
      rr_m = ~v.exp_rdy[1];
      run_frame(v, 1'b0);
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
